// File: rtl/fir_mac_sequencer.sv
// rtl/fir_mac_sequencer.sv - time-multiplexed FIR: one shared MAC sequenced across NTAPS taps per sample
// Optional build macro FIR_SAT_EN: saturate the result to OUT_W bits instead of wrapping.
module fir_mac_sequencer #(
    parameter int IN_W   = 8,
    parameter int COEF_W = 8,
    parameter int NTAPS  = 4,
    parameter int ACC_W  = 18,
    parameter int OUT_W  = 16,
    localparam int AW    = (NTAPS > 1) ? $clog2(NTAPS) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_in_valid,
    input  logic [IN_W-1:0]   i_in_data,
    output logic              o_in_ready,
    input  logic              i_coef_we,
    input  logic [AW-1:0]     i_coef_addr,
    input  logic [COEF_W-1:0] i_coef_data,
    output logic              o_busy,
    output logic [OUT_W-1:0]  o_y,
    output logic              o_y_valid
);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

    localparam logic [ACC_W-1:0] MAX_OUT = ACC_W'((64'd1 << OUT_W) - 64'd1);

    state_t                   r_state, w_next_state;
    logic [IN_W-1:0]          r_x    [NTAPS];
    logic [COEF_W-1:0]        r_coef [NTAPS];
    logic [ACC_W-1:0]         r_acc;
    logic [AW-1:0]            r_idx;
    logic [OUT_W-1:0]         r_y;
    logic                     r_y_valid;

    logic                     w_accept;
    logic                     w_coef_wr;
    logic                     w_last;
    logic [IN_W+COEF_W-1:0]   w_prod;
    logic [ACC_W-1:0]         w_acc_next;
    logic [OUT_W-1:0]         w_result;

    function automatic logic [COEF_W-1:0] coef_rst(input int k);
        case (k)
            0:       coef_rst = COEF_W'(20);
            1:       coef_rst = COEF_W'(15);
            2:       coef_rst = COEF_W'(10);
            default: coef_rst = '0;
        endcase
    endfunction

    assign w_accept   = (r_state == S_IDLE) && i_in_valid;
    assign w_coef_wr  = (r_state == S_IDLE) && i_coef_we &&
                        ({1'b0, i_coef_addr} < (AW+1)'(NTAPS));
    assign w_last     = (r_state == S_MAC) && (r_idx == AW'(NTAPS-1));
    assign w_prod     = r_coef[r_idx] * r_x[r_idx];
    assign w_acc_next = r_acc + ACC_W'(w_prod);

`ifdef FIR_SAT_EN
    assign w_result = (w_acc_next > MAX_OUT) ? {OUT_W{1'b1}} : w_acc_next[OUT_W-1:0];
`else
    assign w_result = w_acc_next[OUT_W-1:0];
`endif

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next_state = S_MAC;
            S_MAC:   if (w_last)   w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // y is loaded on the final MAC edge so it is already valid during the DONE cycle.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int k = 0; k < NTAPS; k++) begin
                r_x[k]    <= '0;
                r_coef[k] <= coef_rst(k);
            end
            r_acc     <= '0;
            r_idx     <= '0;
            r_y       <= '0;
            r_y_valid <= 1'b0;
        end else begin
            r_y_valid <= w_last;
            if (w_last) r_y <= w_result;
            if (w_coef_wr) r_coef[i_coef_addr] <= i_coef_data;
            if (w_accept) begin
                for (int k = NTAPS-1; k >= 1; k--) r_x[k] <= r_x[k-1];
                r_x[0] <= i_in_data;
                r_acc  <= '0;
                r_idx  <= '0;
            end else if (r_state == S_MAC) begin
                r_acc <= w_acc_next;
                r_idx <= r_idx + AW'(1);
            end
        end
    end

    assign o_in_ready = (r_state == S_IDLE) && i_rst;
    assign o_busy     = (r_state != S_IDLE);
    assign o_y        = r_y;
    assign o_y_valid  = r_y_valid;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb/tb_fir_mac_sequencer.sv - scoreboard bench for fir_mac_sequencer
// Honours FIR_SAT_EN in its reference model the same way the design does.
module tb_fir_mac_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready;
    logic        coef_we = 1'b0;
    logic [1:0]  coef_addr = '0;
    logic [7:0]  coef_data = '0;
    logic        busy;
    logic [15:0] y;
    logic        y_valid;

    int checks = 0;
    int failures = 0;
    int n_yvalid = 0;
    int exp_results = 0;

    int m_x    [4];
    int m_coef [4];
    int exp_q  [$];

    always #5 clk = ~clk;

    fir_mac_sequencer dut (
        .i_clk       (clk),
        .i_rst       (rst_n),
        .i_in_valid  (in_valid),
        .i_in_data   (in_data),
        .o_in_ready  (in_ready),
        .i_coef_we   (coef_we),
        .i_coef_addr (coef_addr),
        .i_coef_data (coef_data),
        .o_busy      (busy),
        .o_y         (y),
        .o_y_valid   (y_valid)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model_result();
        longint acc = 0;
        for (int k = 0; k < 4; k++) acc += longint'(m_coef[k]) * longint'(m_x[k]);
`ifdef FIR_SAT_EN
        return (acc > 65535) ? 65535 : int'(acc);
`else
        return int'(acc & 64'hFFFF);
`endif
    endfunction

    function automatic void model_accept(input int d);
        for (int k = 3; k >= 1; k--) m_x[k] = m_x[k-1];
        m_x[0] = d;
        exp_q.push_back(model_result());
        exp_results++;
    endfunction

    always @(negedge clk) begin
        if (rst_n && y_valid) begin
            n_yvalid++;
            if (exp_q.size() == 0) check("unexpected_y_valid", 1, 0);
            else                   check("y", y, exp_q.pop_front());
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        coef_we = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 4; k++) m_x[k] = 0;
        m_coef[0] = 20; m_coef[1] = 15; m_coef[2] = 10; m_coef[3] = 0;
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_y", y, 0);
        check("rst_y_valid", y_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("ready_timeout", 0, 1);
    endtask

    task automatic send(input int d);
        wait_ready();
        in_valid = 1'b1;
        in_data  = 8'(d);
        model_accept(d);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic write_coef(input int a, input int d, input bit lands);
        coef_we   = 1'b1;
        coef_addr = 2'(a);
        coef_data = 8'(d);
        if (lands) m_coef[a] = d;
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("drain_left", exp_q.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        do_reset();
        check("idle_in_ready", in_ready, 1);

        // basic sequence with default coefficients: 20, 55, 100
        send(1);
        send(2);
        send(3);
        drain();

        // timing of a single sample with in_valid held through busy
        wait_ready();
        in_valid = 1'b1;
        in_data  = 8'd5;
        model_accept(5);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check($sformatf("in_ready_c%0d", k), in_ready, (k == 6) ? 1 : 0);
            check($sformatf("y_valid_c%0d", k), y_valid, (k == 5) ? 1 : 0);
            if (k < 5) check($sformatf("y_held_c%0d", k), y, 100);
            if (k == 5) in_valid = 1'b0;
        end
        repeat (10) @(negedge clk);
        check("y_held_after", y, 165);

        // busy write ignored, idle write used
        do_reset();
        send(1);
        send(2);
        send(3);
        write_coef(2, 99, 1'b0);
        drain();
        write_coef(3, 7, 1'b1);
        send(4);
        drain();

        // all-max coefficients and samples
        do_reset();
        for (int k = 0; k < 4; k++) write_coef(k, 255, 1'b1);
        for (int k = 0; k < 4; k++) send(255);
        drain();
`ifdef FIR_SAT_EN
        check("max_y", y, 65535);
`else
        check("max_y", y, 63492);
`endif

        // reset in the middle of MAC
        send(1);
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        exp_results--;
        @(negedge clk);
        check("abort_y", y, 0);
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 0);
        do_reset();
        send(1);
        drain();
        check("after_abort_y", y, 20);

        // simultaneous coefficient write and sample
        do_reset();
        wait_ready();
        coef_we   = 1'b1;
        coef_addr = 2'd0;
        coef_data = 8'd1;
        in_valid  = 1'b1;
        in_data   = 8'd9;
        m_coef[0] = 1;
        model_accept(9);
        @(negedge clk);
        coef_we  = 1'b0;
        in_valid = 1'b0;
        drain();
        check("simul_y", y, 9);

        check("y_valid_count", n_yvalid, exp_results);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
